// File: rtl/cfu_vec_pkg.sv
// Shared types, constants and helpers for the sequential vector CFU.
package cfu_vec_pkg;

   localparam int unsigned ELEN = 8;

   typedef enum logic [2:0] {
      OP_VSETVL  = 3'd0,
      OP_VWRW    = 3'd1,
      OP_VRDW    = 3'd2,
      OP_VDOT    = 3'd3,
      OP_VADDI   = 3'd4,
      OP_VREDSUM = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Index width for an n-entry space; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Signed saturation of a 9-bit sum to int8.
   function automatic logic [7:0] sat8(input logic [8:0] s);
      if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
      return s[7:0];
   endfunction

endpackage

// File: rtl/vec_lane_slice.sv
// LANES-wide combinational MAC, saturating add and reduction with tail mask.
module vec_lane_slice
   import cfu_vec_pkg::*;
#(
   parameter int unsigned LANES = 4,
   parameter int unsigned VL_W  = 6
) (
   input  logic [LANES*ELEN-1:0] a_i,
   input  logic [LANES*ELEN-1:0] b_i,
   input  logic [8:0]            off_i,
   input  logic [7:0]            imm_i,
   input  logic [VL_W-1:0]       base_i,
   input  logic [VL_W-1:0]       vl_i,
   output logic [31:0]           dot_o,
   output logic [31:0]           red_o,
   output logic [LANES*ELEN-1:0] wr_o
);

   logic [7:0]  a8, b8;
   logic [31:0] a32, b32, off32;

   // Per-lane accumulate; lanes at or beyond vl add nothing and keep vd data (b_i).
   always_comb begin
      dot_o = '0;
      red_o = '0;
      wr_o  = b_i;
      a8    = '0;
      b8    = '0;
      a32   = '0;
      b32   = '0;
      off32 = {{23{off_i[8]}}, off_i};
      for (int l = 0; l < int'(LANES); l++) begin
         a8  = a_i[l*ELEN +: ELEN];
         b8  = b_i[l*ELEN +: ELEN];
         a32 = {{24{a8[7]}}, a8};
         b32 = {{24{b8[7]}}, b8};
         if ((int'(base_i) + l) < int'(vl_i)) begin
            dot_o = dot_o + (a32 + off32) * b32;
            red_o = red_o + a32;
            wr_o[l*ELEN +: ELEN] = sat8({a8[7], a8} + {imm_i[7], imm_i});
         end
      end
   end

endmodule

// File: rtl/cfu_vec_seq.sv
// Multi-cycle vector CFU: register file, vl/vtype CSR and chunked int8 ops.
module cfu_vec_seq
   import cfu_vec_pkg::*;
#(
   parameter int unsigned VLEN      = 256,
   parameter int unsigned NUM_VREGS = 32,
   parameter int unsigned LANES     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);

   localparam int unsigned ELEMS  = VLEN / ELEN;
   localparam int unsigned WORDS  = VLEN / 32;
   localparam int unsigned CHUNKS = ELEMS / LANES;
   localparam int unsigned CW     = LANES * ELEN;
   localparam int unsigned RIDX_W = idx_w(NUM_VREGS);
   localparam int unsigned WIDX_W = idx_w(WORDS);
   localparam int unsigned CH_W   = idx_w(CHUNKS);
   localparam int unsigned VB_W   = $clog2(VLEN);
   localparam int unsigned VL_W   = $clog2(ELEMS + 1);
   localparam int unsigned LSH    = $clog2(LANES);

   state_e              state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_data_q, rsp_data_d;
   logic [VL_W-1:0]     vl_q, vl_d;
   logic [31:0]         vtype_q, vtype_d;
   op_e                 op_q, op_d;
   logic [RIDX_W-1:0]   a_idx_q, a_idx_d, b_idx_q, b_idx_d;
   logic [8:0]          off_q, off_d;
   logic [7:0]          imm_q, imm_d;
   logic [CH_W-1:0]     chunk_q, chunk_d;
   logic [31:0]         acc_q, acc_d;
   logic [VLEN-1:0]     vreg_q [NUM_VREGS];

   logic                fire_c, exec_op_c, last_c, word_we_c, chunk_we_c, unused_c;
   op_e                 op_in_c;
   logic [RIDX_W-1:0]   ridx0_c, ridx1_c;
   logic [WIDX_W-1:0]   widx_c;
   logic [VB_W-1:0]     wbit_c, chbit_c;
   logic [VL_W-1:0]     vl_new_c, base_c;
   logic [CW-1:0]       a_chunk_c, b_chunk_c, wr_chunk_c;
   logic [31:0]         dot_c, red_c;

   assign fire_c    = cmd_valid && cmd_ready_q;
   assign op_in_c   = op_e'(cmd_payload_function_id[2:0]);
   assign exec_op_c = (op_in_c == OP_VDOT) || (op_in_c == OP_VADDI) || (op_in_c == OP_VREDSUM);
   assign ridx0_c   = RIDX_W'(32'(cmd_payload_inputs_0[4:0]) % NUM_VREGS);
   assign ridx1_c   = RIDX_W'(32'(cmd_payload_inputs_1[4:0]) % NUM_VREGS);
   assign widx_c    = WIDX_W'(32'(cmd_payload_inputs_1[12:8]) % WORDS);
   assign wbit_c    = VB_W'(32'(widx_c) * 32'd32);
   assign chbit_c   = VB_W'(32'(chunk_q) * CW);
   assign base_c    = VL_W'(32'(chunk_q) * LANES);
   assign last_c    = (chunk_q == CH_W'((32'(vl_q) - 32'd1) >> LSH));
   assign vl_new_c  = (cmd_payload_inputs_0 > 32'(ELEMS)) ? VL_W'(ELEMS)
                                                          : VL_W'(cmd_payload_inputs_0);
   assign a_chunk_c = vreg_q[a_idx_q][chbit_c +: CW];
   assign b_chunk_c = vreg_q[b_idx_q][chbit_c +: CW];
   assign unused_c  = ^{cmd_payload_function_id[9:3], vtype_q};

   assign cmd_ready             = cmd_ready_q;
   assign rsp_valid             = rsp_valid_q;
   assign rsp_payload_outputs_0 = rsp_data_q;

   vec_lane_slice #(.LANES(LANES), .VL_W(VL_W)) u_slice (
      .a_i    (a_chunk_c),
      .b_i    (b_chunk_c),
      .off_i  (off_q),
      .imm_i  (imm_q),
      .base_i (base_c),
      .vl_i   (vl_q),
      .dot_o  (dot_c),
      .red_o  (red_c),
      .wr_o   (wr_chunk_c)
   );

   // FSM state and handshake output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (fire_c) state_d = (exec_op_c && (vl_q != '0)) ? ST_EXEC : ST_RESP;
         ST_EXEC: if (last_c) state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs follow the upcoming state so they are registered.
   always_comb begin
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // Operand latch, CSR update, accumulation and register-file write enables.
   always_comb begin
      rsp_data_d = rsp_data_q;
      vl_d       = vl_q;
      vtype_d    = vtype_q;
      op_d       = op_q;
      a_idx_d    = a_idx_q;
      b_idx_d    = b_idx_q;
      off_d      = off_q;
      imm_d      = imm_q;
      chunk_d    = chunk_q;
      acc_d      = acc_q;
      word_we_c  = 1'b0;
      chunk_we_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fire_c) begin
               op_d    = op_in_c;
               a_idx_d = ridx0_c;
               b_idx_d = ridx1_c;
               off_d   = cmd_payload_inputs_1[16:8];
               imm_d   = cmd_payload_inputs_1[15:8];
               chunk_d = '0;
               acc_d   = '0;
               case (op_in_c)
                  OP_VSETVL: begin
                     vl_d       = vl_new_c;
                     vtype_d    = cmd_payload_inputs_1;
                     rsp_data_d = 32'(vl_new_c);
                  end
                  OP_VWRW: begin
                     word_we_c  = 1'b1;
                     rsp_data_d = '0;
                  end
                  OP_VRDW: rsp_data_d = vreg_q[ridx0_c][wbit_c +: 32];
                  default: rsp_data_d = '0;
               endcase
            end
         end
         ST_EXEC: begin
            acc_d      = acc_q + ((op_q == OP_VDOT) ? dot_c : red_c);
            chunk_d    = chunk_q + CH_W'(1);
            chunk_we_c = (op_q == OP_VADDI);
            if (last_c) rsp_data_d = (op_q == OP_VADDI) ? 32'd0 : acc_d;
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_data_q <= '0;
         vl_q       <= VL_W'(ELEMS);
         vtype_q    <= '0;
         op_q       <= OP_VSETVL;
         a_idx_q    <= '0;
         b_idx_q    <= '0;
         off_q      <= '0;
         imm_q      <= '0;
         chunk_q    <= '0;
         acc_q      <= '0;
      end else begin
         rsp_data_q <= rsp_data_d;
         vl_q       <= vl_d;
         vtype_q    <= vtype_d;
         op_q       <= op_d;
         a_idx_q    <= a_idx_d;
         b_idx_q    <= b_idx_d;
         off_q      <= off_d;
         imm_q      <= imm_d;
         chunk_q    <= chunk_d;
         acc_q      <= acc_d;
      end
   end

   // Vector register file: word writes at accept, chunk writes during EXEC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_VREGS); i++) vreg_q[i] <= '0;
      end else begin
         if (word_we_c)  vreg_q[ridx1_c][wbit_c +: 32] <= cmd_payload_inputs_0;
         if (chunk_we_c) vreg_q[b_idx_q][chbit_c +: CW] <= wr_chunk_c;
      end
   end

endmodule

// File: tb/tb_cfu_vec_seq.sv
// Directed bench for cfu_vec_seq (VLEN=256, NUM_VREGS=32, LANES=4).
module tb_cfu_vec_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  fid;
   logic [31:0] in0, in1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cfu_vec_seq #(.VLEN(256), .NUM_VREGS(32), .LANES(4)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (fid),
      .cmd_payload_inputs_0    (in0),
      .cmd_payload_inputs_1    (in1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_data)
   );

   // Issue one command, wait for its response, report latency in cycles from acceptance.
   task automatic do_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit tmo);
      int n;
      tmo = 1'b0; res = '0; lat = 0; n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; fid = f; in0 = a; in1 = b;
      while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin tmo = 1'b1; cmd_valid = 1'b0; return; end
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      if (lat >= 200) begin tmo = 1'b1; return; end
      res = rsp_data;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; fid = '0; in0 = '0; in1 = '0;
      repeat (3) @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_payload: got %h want 0", rsp_data); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_vsetvl();
      logic [31:0] r; int lat; bit t;
      do_cmd(10'd0, 32'd100, 32'd0, r, lat, t);
      checks++; if (t || r !== 32'd32) begin errors++; $display("FAIL vsetvl_100: got %0d tmo=%0b want 32", r, t); end
      checks++; if (t || lat != 1) begin errors++; $display("FAIL vsetvl_latency: got %0d want 1", lat); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL vsetvl_ready_after: got %b want 1", cmd_ready); end
      do_cmd(10'd0, 32'd10, 32'd0, r, lat, t);
      checks++; if (t || r !== 32'd10) begin errors++; $display("FAIL vsetvl_10: got %0d want 10", r); end
   endtask

   task automatic test_vwrw_vrdw();
      logic [31:0] r; int lat; bit t;
      do_cmd(10'd1, 32'h04030201, 32'h0000_0003, r, lat, t);
      checks++; if (t || r !== 32'h0) begin errors++; $display("FAIL vwrw_result: got %h want 0", r); end
      do_cmd(10'd2, 32'd3, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h04030201) begin errors++; $display("FAIL vrdw_w0: got %h want 04030201", r); end
      do_cmd(10'd2, 32'd3, 32'h0000_0700, r, lat, t);
      checks++; if (t || r !== 32'h0) begin errors++; $display("FAIL vrdw_w7: got %h want 0", r); end
      // word index 9 wraps to word 1
      do_cmd(10'd1, 32'hAABBCCDD, 32'h0000_0903, r, lat, t);
      do_cmd(10'd2, 32'd3, 32'h0000_0100, r, lat, t);
      checks++; if (t || r !== 32'hAABBCCDD) begin errors++; $display("FAIL vrdw_wrap_w1: got %h want aabbccdd", r); end
      // function_id upper bits ignored: 0x3FA -> op 2
      do_cmd(10'h3FA, 32'd3, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h04030201) begin errors++; $display("FAIL vrdw_fid_hi: got %h want 04030201", r); end
   endtask

   task automatic test_vdot();
      logic [31:0] r; int lat; bit t;
      do_cmd(10'd1, 32'h04030201, 32'h0000_0001, r, lat, t);
      do_cmd(10'd1, 32'h08070605, 32'h0000_0101, r, lat, t);
      do_cmd(10'd1, 32'h04030201, 32'h0000_0002, r, lat, t);
      do_cmd(10'd1, 32'h08070605, 32'h0000_0102, r, lat, t);
      do_cmd(10'd0, 32'd6, 32'd0, r, lat, t);
      do_cmd(10'd3, 32'd1, 32'h0000_0002, r, lat, t);
      checks++; if (t || r !== 32'd91) begin errors++; $display("FAIL vdot_off0: got %0d want 91", r); end
      checks++; if (t || lat != 3) begin errors++; $display("FAIL vdot_latency: got %0d want 3", lat); end
      do_cmd(10'd3, 32'd1, 32'h0001_FF02, r, lat, t);
      checks++; if (t || r !== 32'd70) begin errors++; $display("FAIL vdot_offm1: got %0d want 70", r); end
      do_cmd(10'd5, 32'd1, 32'd0, r, lat, t);
      checks++; if (t || r !== 32'd21) begin errors++; $display("FAIL vredsum_vl6: got %0d want 21", r); end
      do_cmd(10'd0, 32'd0, 32'd0, r, lat, t);
      do_cmd(10'd3, 32'd1, 32'h0000_0002, r, lat, t);
      checks++; if (t || r !== 32'd0) begin errors++; $display("FAIL vdot_vl0: got %0d want 0", r); end
      checks++; if (t || lat != 1) begin errors++; $display("FAIL vdot_vl0_latency: got %0d want 1", lat); end
   endtask

   task automatic test_vaddi();
      logic [31:0] r; int lat; bit t;
      do_cmd(10'd1, 32'h0905807F, 32'h0000_0004, r, lat, t);
      do_cmd(10'd1, 32'h11223344, 32'h0000_0005, r, lat, t);
      do_cmd(10'd0, 32'd3, 32'd0, r, lat, t);
      do_cmd(10'd4, 32'd4, 32'h0000_0A05, r, lat, t);
      checks++; if (t || r !== 32'd0) begin errors++; $display("FAIL vaddi_result: got %h want 0", r); end
      checks++; if (t || lat != 2) begin errors++; $display("FAIL vaddi_latency: got %0d want 2", lat); end
      do_cmd(10'd2, 32'd5, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h110F8A7F) begin errors++; $display("FAIL vaddi_vd: got %h want 110f8a7f", r); end
      // in place, imm = -128
      do_cmd(10'd4, 32'd4, 32'h0000_8004, r, lat, t);
      do_cmd(10'd2, 32'd4, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h098580FF) begin errors++; $display("FAIL vaddi_inplace: got %h want 098580ff", r); end
      do_cmd(10'd2, 32'd5, 32'h0000_0100, r, lat, t);
      checks++; if (t || r !== 32'h0) begin errors++; $display("FAIL vaddi_tail_word1: got %h want 0", r); end
   endtask

   task automatic test_reserved();
      logic [31:0] r; int lat; bit t;
      do_cmd(10'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, t);
      checks++; if (t || r !== 32'd0) begin errors++; $display("FAIL reserved6: got %h want 0", r); end
      checks++; if (t || lat != 1) begin errors++; $display("FAIL reserved6_latency: got %0d want 1", lat); end
      do_cmd(10'd2, 32'd4, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h098580FF) begin errors++; $display("FAIL reserved_no_state: got %h want 098580ff", r); end
   endtask

   task automatic test_backpressure();
      logic [31:0] r; int lat; bit t; int n;
      do_cmd(10'd0, 32'd6, 32'd0, r, lat, t);
      @(negedge clk);
      cmd_valid = 1'b1; fid = 10'd5; in0 = 32'd1; in1 = 32'd0;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL bp_rsp_timeout: waited %0d cycles", n); end
      cmd_valid = 1'b1; fid = 10'd1; in0 = 32'hDEAD_BEEF; in1 = 32'h0000_0007;
      for (int k = 0; k < 5; k++) begin
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b want 1", k, rsp_valid); end
         checks++; if (rsp_data !== 32'd21) begin errors++; $display("FAIL bp_payload_%0d: got %0d want 21", k, rsp_data); end
         checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", k, cmd_ready); end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs: valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
      do_cmd(10'd2, 32'd7, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h0) begin errors++; $display("FAIL bp_ignored_cmd: got %h want 0", r); end
   endtask

   task automatic test_reset_mid_exec();
      logic [31:0] r; int lat; bit t; bit seen; int n;
      do_cmd(10'd0, 32'd32, 32'd0, r, lat, t);
      @(negedge clk);
      cmd_valid = 1'b1; fid = 10'd3; in0 = 32'd1; in1 = 32'd2;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_exec_busy: ready=%b valid=%b want 0/0", cmd_ready, rsp_valid); end
      reset = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_exec_async: ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (seen) begin errors++; $display("FAIL mid_exec_no_rsp: got rsp_valid=1 want none"); end
      do_cmd(10'd0, 32'hFFFF_FFFF, 32'd0, r, lat, t);
      checks++; if (t || r !== 32'd32) begin errors++; $display("FAIL mid_exec_vl: got %0d want 32", r); end
      do_cmd(10'd2, 32'd1, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h0) begin errors++; $display("FAIL mid_exec_vreg1: got %h want 0", r); end
      do_cmd(10'd2, 32'd4, 32'h0000_0000, r, lat, t);
      checks++; if (t || r !== 32'h0) begin errors++; $display("FAIL mid_exec_vreg4: got %h want 0", r); end
   endtask

   initial begin
      test_reset();
      test_vsetvl();
      test_vwrw_vrdw();
      test_vdot();
      test_vaddi();
      test_reserved();
      test_backpressure();
      test_reset_mid_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
